// File: rtl/pipe_pkg.sv
// Shared sizing for pipe_ex and its result collector.
// Both blocks import these so widths and latency stay in lockstep.
package pipe_pkg;

  localparam int PIPE_N     = 10;
  localparam int PIPE_LAT   = 3;
  localparam int PIPE_DEPTH = 4;
  localparam int PIPE_CW    = $clog2(PIPE_DEPTH + 1);

endpackage

// File: rtl/pipe_res_fifo.sv
// Synchronous result FIFO with a registered head.
// The head register keeps its last value once the FIFO drains.
module pipe_res_fifo
  import pipe_pkg::*;
#(
  parameter int W     = PIPE_N,
  parameter int DEPTH = PIPE_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_head;

  logic [AW-1:0] w_rnext;
  logic [CW-1:0] w_cnext;

  assign w_rnext = r_rptr + AW'(i_pop);
  assign w_cnext = r_count + CW'(i_push) - CW'(i_pop);

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_head;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(i_push);
      r_rptr  <= w_rnext;
      r_count <= w_cnext;
      // New head may be the word being written this very edge
      if (w_cnext != '0) begin
        if (i_push && (r_wptr == w_rnext)) begin
          r_head <= i_din;
        end else begin
          r_head <= r_mem[w_rnext];
        end
      end
    end
  end

endmodule

// File: rtl/pipe_result_collector.sv
// Collects pipe_ex results into a FIFO, tracking in-flight ops
// to issue credit, and keeping overflow and throughput stats.
module pipe_result_collector
  import pipe_pkg::*;
#(
  parameter int N     = PIPE_N,
  parameter int LAT   = PIPE_LAT,
  parameter int DEPTH = PIPE_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [N-1:0]  f_in,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  output logic          issue_ok,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [15:0]   results_total
);

  logic [LAT-1:0] r_sr;
  logic           r_ovf;
  logic [15:0]    r_total;

  logic           w_arrival;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic           w_full;
  logic           w_empty;
  logic [31:0]    w_credit;

  assign w_arrival = r_sr[LAT-1];
  assign w_pop     = out_valid & out_ready;
  assign w_push    = w_arrival & (~w_full | w_pop);
  assign w_drop    = w_arrival & w_full & ~w_pop;

  assign out_valid = ~w_empty;

  // Pops are ignored so credit is never over-granted
  assign w_credit = 32'(count) + 32'($countones(r_sr));
  assign issue_ok = (w_credit < 32'(DEPTH));

  assign overflow      = r_ovf;
  assign results_total = r_total;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr    <= '0;
      r_ovf   <= 1'b0;
      r_total <= '0;
    end else begin
      r_sr <= LAT'({r_sr, op_valid});
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_push) begin
        r_total <= r_total + 16'd1;
      end
    end
  end

  pipe_res_fifo #(
    .W     (N),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (f_in),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count),
    .o_head  (out_data)
  );

endmodule

// File: tb/tb_pipe_result_collector.sv
// Scoreboard bench for pipe_result_collector against a queue model.
module tb_pipe_result_collector;
  import pipe_pkg::*;

  localparam int N     = PIPE_N;
  localparam int LAT   = PIPE_LAT;
  localparam int DEPTH = PIPE_DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic [N-1:0]  f_in = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          issue_ok;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   results_total;

  pipe_result_collector dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .f_in          (f_in),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .issue_ok      (issue_ok),
    .count         (count),
    .overflow      (overflow),
    .results_total (results_total)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int m_fifo[$];
  int inflight[$];
  int sb_q[$];
  int m_total = 0;
  bit m_ovf = 1'b0;
  int edge_n = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_fifo.delete();
    inflight.delete();
    sb_q.delete();
    m_total = 0;
    m_ovf   = 1'b0;
  endtask

  // Effect of one clock edge, from the rules: results arrive LAT
  // edges after issue; a full FIFO accepts only if it pops too.
  task automatic model_edge(bit ov, logic [N-1:0] f, bit rdy);
    bit arr;
    bit pop;
    edge_n++;
    arr = (inflight.size() > 0) && (inflight[0] == edge_n - LAT);
    pop = (m_fifo.size() > 0) && rdy;
    if (pop) void'(m_fifo.pop_front());
    if (arr) begin
      void'(inflight.pop_front());
      if (m_fifo.size() < DEPTH) begin
        m_fifo.push_back(int'(f));
        sb_q.push_back(int'(f));
        m_total++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (ov) inflight.push_back(edge_n);
  endtask

  task automatic cyc(bit ov, logic [N-1:0] f, bit rdy);
    op_valid  = ov;
    f_in      = f;
    out_ready = rdy;
    @(posedge clk);
    #1;
    if (rst) model_clear();
    else model_edge(ov, f, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_issue_ok", int'(issue_ok), 1);
    cyc(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("count", int'(count), m_fifo.size());
    chk("out_valid", int'(out_valid), (m_fifo.size() != 0) ? 1 : 0);
    chk("issue_ok", int'(issue_ok),
        ((m_fifo.size() + inflight.size()) < DEPTH) ? 1 : 0);
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("results_total", int'(results_total), m_total % 65536);
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %0d expected none",
                 out_data);
      end else begin
        chk("out_data", int'(out_data), sb_q.pop_front());
      end
    end
  end

  logic [N-1:0] vals [4];

  initial begin
    cyc(1'b0, '0, 1'b0);
    do_reset();

    // single result
    cyc(1'b1, N'(800), 1'b0);
    repeat (LAT) cyc(1'b0, N'(800), 1'b0);
    chk("single_data", int'(out_data), 800);
    chk("single_count", int'(count), 1);
    chk("single_total", int'(results_total), 1);
    cyc(1'b0, '0, 1'b1);

    // burst of 4
    vals[0] = N'(800); vals[1] = N'(350);
    vals[2] = N'(84);  vals[3] = N'(99);
    for (int k = 0; k < 4 + LAT; k++) begin
      cyc(k < 4, (k >= LAT) ? vals[k-LAT] : N'(0), 1'b0);
    end
    chk("burst_count", int'(count), 4);
    chk("burst_issue_ok", int'(issue_ok), 0);
    chk("burst_head", int'(out_data), 800);
    repeat (4) cyc(1'b0, '0, 1'b1);
    chk("burst_ovf", int'(overflow), 0);

    // overflow
    for (int k = 0; k < 5 + LAT; k++) begin
      cyc(k < 5, N'(k + 1), 1'b0);
    end
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(count), 4);
    chk("ovf_total", int'(results_total), 9);
    repeat (4) cyc(1'b0, '0, 1'b1);
    chk("ovf_sticky", int'(overflow), 1);
    do_reset();

    // full with concurrent pop
    for (int k = 0; k < 4 + LAT; k++) begin
      cyc(k < 5, N'(10 * (k - LAT + 1)), 1'b0);
    end
    chk("full_count", int'(count), 4);
    cyc(1'b0, N'(50), 1'b1);
    chk("fullpop_count", int'(count), 4);
    chk("fullpop_ovf", int'(overflow), 0);
    chk("fullpop_head", int'(out_data), 20);
    repeat (4) cyc(1'b0, '0, 1'b1);

    // reset mid-flight: 2 buffered, 2 in flight
    for (int k = 0; k < 5; k++) begin
      cyc(k != 2, N'(100 + k), 1'b0);
    end
    chk("mid_count", int'(count), 2);
    do_reset();
    repeat (LAT + 1) cyc(1'b0, N'(77), 1'b0);
    chk("mid_after_count", int'(count), 0);
    chk("mid_after_valid", int'(out_valid), 0);
    chk("mid_after_total", int'(results_total), 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 99) < 55, N'($urandom),
          $urandom_range(0, 99) < 50);
    end
    repeat (DEPTH + LAT + 2) cyc(1'b0, '0, 1'b1);
    do_reset();

    // counter wrap
    for (int k = 0; k < 65537; k++) begin
      cyc(1'b1, N'($urandom), 1'b1);
    end
    repeat (LAT + 2) cyc(1'b0, '0, 1'b1);
    chk("wrap_total", int'(results_total), 1);
    chk("wrap_ovf", int'(overflow), 0);
    chk("wrap_sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
